// File: rtl/network_jam_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : network_jam_initiator
//  Purpose  : Request initiator for the manycore network-jam bench. It stores
//             a known pattern to num_req_p consecutive addresses on a single
//             responder, then loads those addresses back and checks the data.
//             A credit counter limits the number of requests in flight.
//  Ports    : clk_i, reset_n_i      - clock, async active-low reset
//             start_i               - pulse, starts a run from IDLE or DONE
//             my_x_i/my_y_i         - source coordinate (captured at start)
//             dest_x_i/dest_y_i     - responder coordinate (captured at start)
//             base_addr_i           - first sweep address (captured at start)
//             link_sif_i/link_sif_o - link bundle {fwd link, rev link}
//             done_o, pass_o        - run complete / run clean
//             err_cnt_o             - saturating error count
//  Revision : 1.0 - initial release
// ============================================================================
//  Link bundle layout (MSB..LSB), both directions:
//    { fwd_v, fwd_pkt[fwd_pkt_w], fwd_ready_and_rev,
//      rev_v, rev_pkt[ret_pkt_w], rev_ready_and_rev }
//  Request packet  (MSB..LSB): addr, op[1:0], mask, payload, load_id,
//                              src_y, src_x, dst_y, dst_x
//  Return packet   (MSB..LSB): type[1:0], data, load_id, y, x
//  op  : 2'b00 load, 2'b01 store
//  type: 2'b00 store credit, 2'b01 load data
// ============================================================================
module network_jam_initiator #(
  parameter int addr_width_p    = 16,
  parameter int data_width_p    = 32,
  parameter int load_id_width_p = 5,
  parameter int x_cord_width_p  = 4,
  parameter int y_cord_width_p  = 3,
  parameter int num_req_p       = 16,
  parameter int max_out_p       = 4,
  parameter int link_sif_width_lp =
      (addr_width_p + 2 + data_width_p/8 + data_width_p + load_id_width_p
       + 2*(x_cord_width_p + y_cord_width_p) + 2)
    + (2 + data_width_p + load_id_width_p + x_cord_width_p + y_cord_width_p + 2)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         start_i,
  input  logic [x_cord_width_p-1:0]    my_x_i,
  input  logic [y_cord_width_p-1:0]    my_y_i,
  input  logic [x_cord_width_p-1:0]    dest_x_i,
  input  logic [y_cord_width_p-1:0]    dest_y_i,
  input  logic [addr_width_p-1:0]      base_addr_i,
  input  logic [link_sif_width_lp-1:0] link_sif_i,
  output logic [link_sif_width_lp-1:0] link_sif_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic [7:0]                   err_cnt_o
);

  localparam int mask_w_lp    = data_width_p / 8;
  localparam int fwd_pkt_w_lp = addr_width_p + 2 + mask_w_lp + data_width_p
                                + load_id_width_p + 2*(x_cord_width_p + y_cord_width_p);
  localparam int ret_pkt_w_lp = 2 + data_width_p + load_id_width_p
                                + x_cord_width_p + y_cord_width_p;
  localparam int idx_w_lp     = $clog2(num_req_p + 1);
  localparam int out_w_lp     = $clog2(max_out_p + 1);

  localparam logic [idx_w_lp-1:0]      num_req_idx_lp = idx_w_lp'(num_req_p);
  localparam logic [out_w_lp-1:0]      max_out_lp     = out_w_lp'(max_out_p);
  localparam logic [load_id_width_p:0] num_req_id_lp  = (load_id_width_p + 1)'(num_req_p);

  localparam logic [1:0] op_load_lp   = 2'b00;
  localparam logic [1:0] op_store_lp  = 2'b01;
  localparam logic [1:0] ret_load_lp  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STORE   = 3'd1,
    S_DRAIN_S = 3'd2,
    S_LOAD    = 3'd3,
    S_DRAIN_L = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  // Pattern stored at request i and expected back from load i.
  function automatic logic [data_width_p-1:0] pattern_f(input logic [load_id_width_p-1:0] id);
    logic [31:0] sum;
    sum = 32'hA5A5_0000 + 32'(id);
    return data_width_p'(sum);
  endfunction

  // --------------------------------------------------------------------------
  // Link decode
  // --------------------------------------------------------------------------
  logic                       fwd_in_v_w;
  logic [fwd_pkt_w_lp-1:0]    fwd_in_pkt_w;
  logic                       fwd_ready_w;
  logic                       rev_in_v_w;
  logic [ret_pkt_w_lp-1:0]    rev_in_pkt_w;
  logic                       rev_ready_w;

  assign fwd_in_v_w   = link_sif_i[link_sif_width_lp-1];
  assign fwd_in_pkt_w = link_sif_i[ret_pkt_w_lp+3 +: fwd_pkt_w_lp];
  assign fwd_ready_w  = link_sif_i[ret_pkt_w_lp+2];
  assign rev_in_v_w   = link_sif_i[ret_pkt_w_lp+1];
  assign rev_in_pkt_w = link_sif_i[ret_pkt_w_lp:1];
  assign rev_ready_w  = link_sif_i[0];

  logic [x_cord_width_p-1:0]  ret_x_w;
  logic [y_cord_width_p-1:0]  ret_y_w;
  logic [load_id_width_p-1:0] ret_id_w;
  logic [data_width_p-1:0]    ret_data_w;
  logic [1:0]                 ret_type_w;

  assign ret_x_w    = rev_in_pkt_w[0 +: x_cord_width_p];
  assign ret_y_w    = rev_in_pkt_w[x_cord_width_p +: y_cord_width_p];
  assign ret_id_w   = rev_in_pkt_w[x_cord_width_p+y_cord_width_p +: load_id_width_p];
  assign ret_data_w = rev_in_pkt_w[x_cord_width_p+y_cord_width_p+load_id_width_p +: data_width_p];
  assign ret_type_w = rev_in_pkt_w[ret_pkt_w_lp-1 -: 2];

  // Inbound requests are dropped and the return port never transmits, so
  // these fields carry nothing this block acts on.
  logic unused_w;
  assign unused_w = ^{fwd_in_pkt_w, rev_ready_w, ret_x_w, ret_y_w};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                    state_q, state_d;
  logic [idx_w_lp-1:0]       idx_q, idx_d;
  logic [out_w_lp-1:0]       out_q, out_d;
  logic [7:0]                err_q, err_d;
  logic                      done_q, done_d;
  logic [addr_width_p-1:0]   base_q, base_d;
  logic [x_cord_width_p-1:0] my_x_q, my_x_d, dest_x_q, dest_x_d;
  logic [y_cord_width_p-1:0] my_y_q, my_y_d, dest_y_q, dest_y_d;

  // --------------------------------------------------------------------------
  // Request generation; valid is a function of registers only
  // --------------------------------------------------------------------------
  logic                    fwd_v_w;
  logic                    is_store_w;
  logic [fwd_pkt_w_lp-1:0] fwd_pkt_w;
  logic                    issue_w;

  assign is_store_w = (state_q == S_STORE);
  assign fwd_v_w    = ((state_q == S_STORE) || (state_q == S_LOAD))
                      && (idx_q < num_req_idx_lp) && (out_q < max_out_lp);
  assign issue_w    = fwd_v_w && fwd_ready_w;

  // Mask is all ones for both ops; the responder ignores it on loads.
  assign fwd_pkt_w = {
    base_q + addr_width_p'(idx_q),
    is_store_w ? op_store_lp : op_load_lp,
    {mask_w_lp{1'b1}},
    is_store_w ? pattern_f(load_id_width_p'(idx_q)) : {data_width_p{1'b0}},
    load_id_width_p'(idx_q),
    my_y_q, my_x_q, dest_y_q, dest_x_q
  };

  // --------------------------------------------------------------------------
  // Return checking. A return only releases a credit when something is
  // outstanding and its id is in range; otherwise it is counted as an error
  // and leaves the counter alone.
  // --------------------------------------------------------------------------
  logic       ret_id_ok_w;
  logic       ret_ok_w;
  logic       ret_bad_w;
  logic [8:0] err_sum_w;
  logic [7:0] err_sat_w;

  assign ret_id_ok_w = ({1'b0, ret_id_w} < num_req_id_lp);
  assign ret_ok_w    = rev_in_v_w && (out_q != '0) && ret_id_ok_w;
  assign ret_bad_w   = rev_in_v_w &&
                       (!ret_ok_w ||
                        ((ret_type_w == ret_load_lp) && (ret_data_w != pattern_f(ret_id_w))));

  // A dropped inbound request and a bad return can land in the same cycle.
  assign err_sum_w = {1'b0, err_q} + 9'(fwd_in_v_w) + 9'(ret_bad_w);
  assign err_sat_w = (err_sum_w > 9'd255) ? 8'hFF : err_sum_w[7:0];

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = done_q;
    base_d   = base_q;
    my_x_d   = my_x_q;
    my_y_d   = my_y_q;
    dest_x_d = dest_x_q;
    dest_y_d = dest_y_q;
    out_d    = out_q + out_w_lp'(issue_w) - out_w_lp'(ret_ok_w);
    err_d    = err_sat_w;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d  = S_STORE;
          idx_d    = '0;
          err_d    = '0;
          done_d   = 1'b0;
          base_d   = base_addr_i;
          my_x_d   = my_x_i;
          my_y_d   = my_y_i;
          dest_x_d = dest_x_i;
          dest_y_d = dest_y_i;
        end
      end
      S_STORE, S_LOAD: begin
        if (issue_w) begin
          idx_d = idx_q + idx_w_lp'(1);
        end
        if (idx_q == num_req_idx_lp) begin
          state_d = (state_q == S_STORE) ? S_DRAIN_S : S_DRAIN_L;
        end
      end
      S_DRAIN_S: begin
        if (out_q == '0) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_DRAIN_L: begin
        if (out_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      out_q    <= '0;
      err_q    <= '0;
      done_q   <= 1'b0;
      base_q   <= '0;
      my_x_q   <= '0;
      my_y_q   <= '0;
      dest_x_q <= '0;
      dest_y_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      err_q    <= err_d;
      done_q   <= done_d;
      base_q   <= base_d;
      my_x_q   <= my_x_d;
      my_y_q   <= my_y_d;
      dest_x_q <= dest_x_d;
      dest_y_q <= dest_y_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (out_q <= max_out_lp);
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs: inbound fwd and rev are always ready, rev-out never valid
  // --------------------------------------------------------------------------
  assign link_sif_o = {fwd_v_w, fwd_pkt_w, 1'b1,
                       1'b0, {ret_pkt_w_lp{1'b0}}, 1'b1};
  assign done_o     = done_q;
  assign pass_o     = done_q && (err_q == 8'd0);
  assign err_cnt_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_network_jam_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_network_jam_initiator
//  Purpose  : Scoreboard bench. A responder model answers requests from a
//             memory; the start task queues the expected request stream and a
//             monitor pops/compares on every fwd handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_network_jam_initiator;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int LW    = 5;
  localparam int XW    = 4;
  localparam int YW    = 3;
  localparam int NR    = 16;
  localparam int MO    = 4;
  localparam int MW    = DW / 8;
  localparam int FW    = AW + 2 + MW + DW + LW + 2*(XW + YW);
  localparam int RW    = 2 + DW + LW + XW + YW;
  localparam int LINKW = FW + 2 + RW + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n = 1'b0;
  logic             start   = 1'b0;
  logic [XW-1:0]    my_x    = 4'd2;
  logic [YW-1:0]    my_y    = 3'd5;
  logic [XW-1:0]    dest_x  = 4'd9;
  logic [YW-1:0]    dest_y  = 3'd1;
  logic [AW-1:0]    base_addr = 16'h0100;
  logic [LINKW-1:0] link_in;
  logic [LINKW-1:0] link_out;
  logic             done;
  logic             pass;
  logic [7:0]       err_cnt;

  logic          fwd_in_v   = 1'b0;
  logic [FW-1:0] fwd_in_pkt = '0;
  logic          fwd_ready  = 1'b1;
  logic          rev_in_v   = 1'b0;
  logic [RW-1:0] rev_in_pkt = '0;

  assign link_in = {fwd_in_v, fwd_in_pkt, fwd_ready, rev_in_v, rev_in_pkt, 1'b1};

  logic          req_v;
  logic [FW-1:0] req_pkt;
  logic          fwd_in_ready;
  logic          rev_out_v;
  logic          rev_in_ready;

  assign req_v        = link_out[LINKW-1];
  assign req_pkt      = link_out[LINKW-2 -: FW];
  assign fwd_in_ready = link_out[RW+2];
  assign rev_out_v    = link_out[RW+1];
  assign rev_in_ready = link_out[0];

  network_jam_initiator #(
    .addr_width_p    (AW),
    .data_width_p    (DW),
    .load_id_width_p (LW),
    .x_cord_width_p  (XW),
    .y_cord_width_p  (YW),
    .num_req_p       (NR),
    .max_out_p       (MO)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .start_i     (start),
    .my_x_i      (my_x),
    .my_y_i      (my_y),
    .dest_x_i    (dest_x),
    .dest_y_i    (dest_y),
    .base_addr_i (base_addr),
    .link_sif_i  (link_in),
    .link_sif_o  (link_out),
    .done_o      (done),
    .pass_o      (pass),
    .err_cnt_o   (err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Expected request stream
  // --------------------------------------------------------------------------
  logic [FW-1:0] exp_q[$];

  function automatic logic [FW-1:0] mk_req(input bit st, input int i);
    logic [AW-1:0] a;
    logic [31:0]   p;
    logic [DW-1:0] d;
    a = base_addr + AW'(i);
    p = 32'hA5A5_0000 + 32'(i);
    d = st ? DW'(p) : '0;
    return {a, (st ? 2'b01 : 2'b00), {MW{1'b1}}, d, LW'(i), my_y, my_x, dest_y, dest_x};
  endfunction

  // --------------------------------------------------------------------------
  // Responder: memory-backed, returns presented one cycle after a handshake
  // --------------------------------------------------------------------------
  typedef struct {
    logic [RW-1:0] pkt;
    int            rel;
  } ret_t;

  ret_t          ret_q[$];
  logic [DW-1:0] mem [int];
  int            cyc        = 0;
  bit            hold       = 1'b0;
  bit            rand_rdy   = 1'b0;
  int            corrupt_id = -1;

  initial begin : responder
    logic [AW-1:0] a;
    logic [1:0]    op;
    logic [DW-1:0] d;
    logic [LW-1:0] id;
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        ret_q.delete();
        rev_in_v = 1'b0;
        continue;
      end
      fwd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!hold && ret_q.size() > 0 && ret_q[0].rel <= cyc) begin
        rev_in_v   = 1'b1;
        rev_in_pkt = ret_q[0].pkt;
        void'(ret_q.pop_front());
      end else begin
        rev_in_v = 1'b0;
      end
      if (req_v && fwd_ready) begin
        a  = req_pkt[FW-1 -: AW];
        op = req_pkt[FW-AW-1 -: 2];
        d  = req_pkt[LW + 2*(XW+YW) +: DW];
        id = req_pkt[2*(XW+YW) +: LW];
        sx = req_pkt[XW+YW +: XW];
        sy = req_pkt[2*XW+YW +: YW];
        if (op == 2'b01) begin
          mem[int'(a)] = d;
          ret_q.push_back('{pkt: {2'b00, {DW{1'b0}}, id, sy, sx}, rel: cyc + 1});
        end else begin
          d = mem.exists(int'(a)) ? mem[int'(a)] : '0;
          if (int'(id) == corrupt_id) d = d ^ 32'h1;
          ret_q.push_back('{pkt: {2'b01, d, id, sy, sx}, rel: cyc + 1});
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: compares each handshaken request and stall stability
  // --------------------------------------------------------------------------
  int            hs_cnt  = 0;
  int            load_hs = 0;
  bit            stalled = 1'b0;
  logic [FW-1:0] held_pkt;

  initial begin : monitor
    logic [FW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check("stall_valid", 128'(req_v), 128'(1'b1));
        check("stall_pkt", 128'(req_pkt), 128'(held_pkt));
      end
      if (req_v && fwd_ready) begin
        hs_cnt++;
        if (req_pkt[FW-AW-1 -: 2] == 2'b00) load_hs++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL req_unexpected: got %h required none", req_pkt);
        end else begin
          e = exp_q.pop_front();
          check("req_pkt", 128'(req_pkt), 128'(e));
        end
      end
      stalled  = req_v && !fwd_ready;
      held_pkt = req_pkt;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic start_run();
    @(negedge clk);
    #2;
    start = 1'b1;
    for (int i = 0; i < NR; i++) exp_q.push_back(mk_req(1'b1, i));
    for (int i = 0; i < NR; i++) exp_q.push_back(mk_req(1'b0, i));
    @(negedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #2;
    check({nm, "_done"}, 128'(done), 128'(1'b1));
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #2;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin : stim
    int h0;
    int n;

    // Reset state
    #12;
    check("rst_done", 128'(done), 128'(1'b0));
    check("rst_pass", 128'(pass), 128'(1'b0));
    check("rst_err", 128'(err_cnt), 128'(8'd0));
    check("rst_req_v", 128'(req_v), 128'(1'b0));
    check("rst_rev_out_v", 128'(rev_out_v), 128'(1'b0));
    check("fwd_in_ready", 128'(fwd_in_ready), 128'(1'b1));
    check("rev_in_ready", 128'(rev_in_ready), 128'(1'b1));
    @(negedge clk);
    #2;
    reset_n = 1'b1;

    // Basic run, base 0x100, no backpressure
    h0 = hs_cnt;
    start_run();
    wait_done("basic");
    check("basic_pass", 128'(pass), 128'(1'b1));
    check("basic_err", 128'(err_cnt), 128'(8'd0));
    check("basic_hs", 128'(hs_cnt - h0), 128'(32));
    check("basic_expq", 128'(exp_q.size()), 128'(0));

    // Backpressure with address wrap at the top of the address space
    base_addr = 16'hFFF8;
    rand_rdy  = 1'b1;
    h0 = hs_cnt;
    start_run();
    wait_done("bp");
    rand_rdy = 1'b0;
    check("bp_pass", 128'(pass), 128'(1'b1));
    check("bp_hs", 128'(hs_cnt - h0), 128'(32));
    check("bp_expq", 128'(exp_q.size()), 128'(0));

    // Credit limit: returns held, issue stops at max_out
    base_addr = 16'h0200;
    hold = 1'b1;
    h0 = hs_cnt;
    start_run();
    wait_cycles(20);
    check("credit_hs", 128'(hs_cnt - h0), 128'(MO));
    check("credit_req_v", 128'(req_v), 128'(1'b0));
    check("credit_out", 128'(dut.out_q), 128'(MO));
    check("credit_done", 128'(done), 128'(1'b0));
    hold = 1'b0;
    wait_done("credit");
    check("credit_pass", 128'(pass), 128'(1'b1));

    // Data error on load_id 3
    corrupt_id = 3;
    start_run();
    wait_done("derr");
    corrupt_id = -1;
    check("derr_err", 128'(err_cnt), 128'(8'd1));
    check("derr_pass", 128'(pass), 128'(1'b0));

    // Protocol errors from IDLE
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    check("idle_err0", 128'(err_cnt), 128'(8'd0));
    ret_q.push_back('{pkt: {2'b01, 32'hA5A5_0000, 5'd0, my_y, my_x}, rel: 0});
    wait_cycles(3);
    check("unsolicited_err", 128'(err_cnt), 128'(8'd1));
    fwd_in_v   = 1'b1;
    fwd_in_pkt = mk_req(1'b1, 7);
    #1;
    check("fwd_in_ready_req", 128'(fwd_in_ready), 128'(1'b1));
    @(negedge clk);
    #2;
    fwd_in_v = 1'b0;
    wait_cycles(1);
    check("fwd_in_err", 128'(err_cnt), 128'(8'd2));
    for (int i = 0; i < 300; i++)
      ret_q.push_back('{pkt: {2'b01, 32'h0, 5'd31, my_y, my_x}, rel: 0});
    wait_cycles(310);
    check("err_saturate", 128'(err_cnt), 128'(8'd255));
    check("rev_out_never", 128'(rev_out_v), 128'(1'b0));

    // Reset in the middle of the load sweep
    base_addr = 16'h0300;
    load_hs = 0;
    start_run();
    n = 0;
    while (load_hs < 5 && n < 500) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("reach_load5", 128'(load_hs >= 5), 128'(1'b1));
    @(posedge clk);
    #2;
    check("mid_idx", 128'(dut.idx_q), 128'(5));
    reset_n = 1'b0;
    #1;
    check("mid_rst_req_v", 128'(req_v), 128'(1'b0));
    check("mid_rst_done", 128'(done), 128'(1'b0));
    check("mid_rst_err", 128'(err_cnt), 128'(8'd0));
    exp_q.delete();
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    start_run();
    wait_done("after_rst");
    check("after_rst_pass", 128'(pass), 128'(1'b1));
    check("after_rst_expq", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
